// File: rtl/maxnet_datapath.sv
// rtl/maxnet_datapath.sv - four-neuron MaxNet lateral-inhibition datapath
//
// Holds four unsigned activations a[0..3]. Each cycle it either loads the
// external activations or applies one inhibition step:
//     next_i = max(a_i - ((sum of the other three) >> EPS_SHIFT), 0)
// finish, winner, winner_valid and max_out are combinational from the registers.
//
// Optional feature: MAXNET_ITER_LIMIT_EN adds an 8-bit iteration counter that
// forces finish once MAX_ITER iterations have run since the last load.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   load_reg     in   register write enable
//   sel          in   0: load x0..x3, 1: load inhibition result
//   x0..x3       in   initial activations, WIDTH bits each
//   finish       out  at most one register nonzero (or iteration limit hit)
//   winner       out  index of lowest-numbered nonzero register, 0 if none
//   winner_valid out  exactly one register nonzero
//   max_out      out  a[winner], 0 if all registers are zero
module maxnet_datapath #(
    parameter int WIDTH     = 16,
    parameter int EPS_SHIFT = 3,
    parameter int MAX_ITER  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_reg,
    input  logic             sel,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    output logic             finish,
    output logic [1:0]       winner,
    output logic             winner_valid,
    output logic [WIDTH-1:0] max_out
);

    logic [WIDTH-1:0] a      [4];
    logic [WIDTH-1:0] x      [4];
    logic [WIDTH-1:0] next_a [4];
    logic [WIDTH+1:0] total;
    logic [WIDTH+1:0] others [4];
    logic [WIDTH+1:0] inh    [4];
    logic [2:0]       nz_count;
    logic             any_nz;

    assign x[0] = x0;
    assign x[1] = x1;
    assign x[2] = x2;
    assign x[3] = x3;

    // Inhibition step. total is two bits wider than an activation so the
    // four-way sum cannot overflow; inh_i can exceed a_i, hence the clamp.
    always_comb begin
        total = '0;
        for (int i = 0; i < 4; i++) begin
            total = total + {2'b00, a[i]};
        end
        for (int i = 0; i < 4; i++) begin
            others[i] = total - {2'b00, a[i]};
            inh[i]    = others[i] >> EPS_SHIFT;
            if ({2'b00, a[i]} > inh[i]) begin
                // inh[i] < a[i] here, so its upper two bits are zero
                next_a[i] = a[i] - inh[i][WIDTH-1:0];
            end else begin
                next_a[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                a[i] <= '0;
            end
        end else if (load_reg) begin
            for (int i = 0; i < 4; i++) begin
                a[i] <= sel ? next_a[i] : x[i];
            end
        end
    end

`ifdef MAXNET_ITER_LIMIT_EN
    logic [7:0] iter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter <= '0;
        end else if (load_reg) begin
            if (!sel) begin
                iter <= '0;
            end else if (iter != 8'hFF) begin
                iter <= iter + 8'd1;
            end
        end
    end
`endif

    // Status decode. The loop runs high to low so the last assignment wins,
    // giving index 0 the highest priority.
    always_comb begin
        nz_count = '0;
        winner   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (a[i] != '0) begin
                nz_count = nz_count + 3'd1;
                winner   = 2'(i);
            end
        end
        any_nz       = (nz_count != 3'd0);
        winner_valid = (nz_count == 3'd1);
        max_out      = any_nz ? a[winner] : '0;
`ifdef MAXNET_ITER_LIMIT_EN
        // Breaks exact ties that stall once inh truncates to zero.
        finish = (nz_count <= 3'd1) || (iter >= 8'(MAX_ITER));
`else
        finish = (nz_count <= 3'd1);
`endif
    end

endmodule

// File: tb/tb_maxnet_datapath.sv
// tb/tb_maxnet_datapath.sv - directed self-checking bench for maxnet_datapath
module tb_maxnet_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_reg = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic        finish;
    logic [1:0]  winner;
    logic        winner_valid;
    logic [15:0] max_out;

    int vectors = 0;
    int miscompares = 0;
    int iters;

    maxnet_datapath #(.WIDTH(16), .EPS_SHIFT(3), .MAX_ITER(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_reg     (load_reg),
        .sel          (sel),
        .x0           (x0),
        .x1           (x1),
        .x2           (x2),
        .x3           (x3),
        .finish       (finish),
        .winner       (winner),
        .winner_valid (winner_valid),
        .max_out      (max_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, " a0"}, 32'(dut.a[0]), 32'(e0));
        check({tag, " a1"}, 32'(dut.a[1]), 32'(e1));
        check({tag, " a2"}, 32'(dut.a[2]), 32'(e2));
        check({tag, " a3"}, 32'(dut.a[3]), 32'(e3));
    endtask

    // One clock: inputs change on the falling edge, outputs sampled 1ns after the rising edge.
    task automatic cycle(input logic ld, input logic s);
        @(negedge clk);
        load_reg = ld;
        sel      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v0, input int v1, input int v2, input int v3);
        @(negedge clk);
        x0 = 16'(v0); x1 = 16'(v1); x2 = 16'(v2); x3 = 16'(v3);
        cycle(1'b1, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        check("reset finish", 32'(finish), 1);
        check("reset winner", 32'(winner), 0);
        check("reset winner_valid", 32'(winner_valid), 0);
        check("reset max_out", 32'(max_out), 0);
        @(negedge clk);
        rst = 1'b0;

        // Initial load and first iteration
        load(40, 30, 20, 10);
        check("load finish", 32'(finish), 0);
        check("load max_out", 32'(max_out), 40);
        cycle(1'b1, 1'b1);
        check_regs("iter1", 33, 22, 10, 0);
        check("iter1 finish", 32'(finish), 0);
        cycle(1'b1, 1'b1);
        check_regs("iter2", 29, 17, 4, 0);

        // Iterate to completion: 25,0,0,0 after eight iterations total
        iters = 2;
        while (!finish && iters < 20) begin
            cycle(1'b1, 1'b1);
            iters++;
        end
        check("converge iterations", 32'(iters), 8);
        check("converge finish", 32'(finish), 1);
        check("converge winner", 32'(winner), 0);
        check("converge winner_valid", 32'(winner_valid), 1);
        check("converge max_out", 32'(max_out), 25);

        // Single nonzero input wins immediately
        load(0, 0, 50, 0);
        check("single finish", 32'(finish), 1);
        check("single winner", 32'(winner), 2);
        check("single winner_valid", 32'(winner_valid), 1);
        check("single max_out", 32'(max_out), 50);

        // Hold: sel ignored while load_reg is low
        load(40, 30, 20, 10);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        check_regs("hold", 40, 30, 20, 10);
        check("hold finish", 32'(finish), 0);
        check("hold winner", 32'(winner), 0);

        // Stalled tie: 8,8 -> 7,7 -> 7,7 ...
        load(8, 8, 0, 0);
        cycle(1'b1, 1'b1);
        check_regs("tie iter1", 7, 7, 0, 0);
        for (int i = 2; i <= 14; i++) cycle(1'b1, 1'b1);
        check_regs("tie iter14", 7, 7, 0, 0);
        check("tie iter14 finish", 32'(finish), 0);
        cycle(1'b1, 1'b1);
`ifdef MAXNET_ITER_LIMIT_EN
        check("tie iter15 finish", 32'(finish), 1);
        check("tie iter15 count", 32'(dut.iter), 15);
`else
        check("tie iter15 finish", 32'(finish), 0);
`endif
        check("tie iter15 winner_valid", 32'(winner_valid), 0);
        check("tie iter15 max_out", 32'(max_out), 7);

        // Reload clears the iteration state
        load(40, 30, 20, 10);
        check("reload finish", 32'(finish), 0);
`ifdef MAXNET_ITER_LIMIT_EN
        check("reload iter", 32'(dut.iter), 0);
`endif

        // Reset mid-operation, asserted between two iterate edges
        cycle(1'b1, 1'b1);
        check_regs("pre-reset", 33, 22, 10, 0);
        #2;
        rst = 1'b1;
        #1;
        check_regs("async reset", 0, 0, 0, 0);
        check("async reset finish", 32'(finish), 1);
        check("async reset winner_valid", 32'(winner_valid), 0);
        check("async reset max_out", 32'(max_out), 0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b1);
        check_regs("post-reset iterate", 0, 0, 0, 0);
        check("post-reset winner", 32'(winner), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
